// File: rtl/edsac_tp_pkg.sv
// Shared types and constants for the EDSAC teleprinter drive.
// Optional feature macro used by teleprinter_drive: TP_SHIFT_TRACK_EN.
package edsac_tp_pkg;

    // Width of the character-period countdown.
    localparam int TIMER_W = 16;

    // Teleprinter shift codes.
    localparam logic [4:0] FIGS_CODE = 5'b01011;
    localparam logic [4:0] LTRS_CODE = 5'b01111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        PRINT = 2'd2,
        DONE  = 2'd3
    } tp_state_e;

    // True for either shift code.
    function automatic logic is_shift(input logic [4:0] code);
        return (code == FIGS_CODE) || (code == LTRS_CODE);
    endfunction

endpackage

// File: rtl/tp_char_timer.sv
// Character-period down counter: load, count down while enabled, stop at 0.
module tp_char_timer
    import edsac_tp_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               en_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement while enabled, never below 0.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/teleprinter_drive.sv
// EDSAC teleprinter drive: offers each character to a host logger, then
// holds the mechanism busy for one character period and pulses ep_done.
// Define TP_SHIFT_TRACK_EN to absorb shift codes into a tracked tp_figs.
module teleprinter_drive
    import edsac_tp_pkg::*;
#(
    parameter int CHAR_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       char_valid,
    input  logic [4:0] char_in,
    output logic       tp_valid,
    input  logic       tp_ready,
    output logic [4:0] tp_code,
    output logic       tp_figs,
    output logic       tp_busy,
    output logic       ep_done,
    output logic       err_overrun
);

    localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(CHAR_CYCLES - 1);

    tp_state_e  state_q, state_d;
    logic [4:0] code_q, code_d;
    logic       err_q, err_d;
    logic       tmr_load, tmr_en, tmr_zero;
`ifdef TP_SHIFT_TRACK_EN
    logic       figs_q, figs_d;
`endif

    tp_char_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (LOAD_VAL),
        .en_i       (tmr_en),
        .zero_o     (tmr_zero)
    );

    // Next-state and output decode; PRINT is entered only together with a timer load.
    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        err_d    = err_q | (char_valid && (state_q != IDLE));
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tp_valid = 1'b0;
        ep_done  = 1'b0;
`ifdef TP_SHIFT_TRACK_EN
        figs_d   = figs_q;
`endif
        case (state_q)
            IDLE: begin
                if (char_valid) begin
`ifdef TP_SHIFT_TRACK_EN
                    if (is_shift(char_in)) begin
                        figs_d   = (char_in == FIGS_CODE);
                        tmr_load = 1'b1;
                        state_d  = PRINT;
                    end else begin
                        code_d  = char_in;
                        state_d = OFFER;
                    end
`else
                    code_d  = char_in;
                    state_d = OFFER;
`endif
                end
            end
            OFFER: begin
                tp_valid = 1'b1;
                if (tp_ready) begin
                    tmr_load = 1'b1;
                    state_d  = PRINT;
                end
            end
            PRINT: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ep_done = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched code and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            err_q   <= err_d;
        end
    end

`ifdef TP_SHIFT_TRACK_EN
    // Tracked shift state; resets to letters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            figs_q <= 1'b0;
        end else begin
            figs_q <= figs_d;
        end
    end
    assign tp_figs = figs_q;
`else
    assign tp_figs = 1'b0;
`endif

    assign tp_code     = code_q;
    assign tp_busy     = (state_q != IDLE);
    assign err_overrun = err_q;

endmodule

// File: tb/tb_teleprinter_drive.sv
// Scoreboard bench for teleprinter_drive with CHAR_CYCLES=4.
// Stimulus pushes expected offers and ep_done cycles; a negedge monitor pops and checks.
module tb_teleprinter_drive;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       char_valid;
    logic [4:0] char_in;
    logic       tp_valid;
    logic       tp_ready;
    logic [4:0] tp_code;
    logic       tp_figs;
    logic       tp_busy;
    logic       ep_done;
    logic       err_overrun;

    typedef struct {
        logic [4:0] code;
        logic       figs;
    } tx_t;

    tx_t exp_tx[$];
    int  exp_done[$];
    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;

    teleprinter_drive #(.CHAR_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .char_valid  (char_valid),
        .char_in     (char_in),
        .tp_valid    (tp_valid),
        .tp_ready    (tp_ready),
        .tp_code     (tp_code),
        .tp_figs     (tp_figs),
        .tp_busy     (tp_busy),
        .ep_done     (ep_done),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance n cycles, landing just after the rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle char_valid strobe; returns the cycle it was presented in.
    task automatic send(input logic [4:0] code, output int c0);
        char_valid = 1'b1;
        char_in    = code;
        c0         = cyc;
        step(1);
        char_valid = 1'b0;
    endtask

    task automatic push_tx(input logic [4:0] code, input logic figs);
        tx_t t;
        t.code = code;
        t.figs = figs;
        exp_tx.push_back(t);
    endtask

    // Monitor: handshakes, ep_done timing and offer stability under backpressure.
    logic       prev_stall = 1'b0;
    logic [4:0] prev_code  = '0;
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("stall_valid_held", {31'd0, tp_valid}, 32'd1);
            chk("stall_code_held", {27'd0, tp_code}, {27'd0, prev_code});
        end
        if (tp_valid && tp_ready) begin
            if (exp_tx.size() == 0) begin
                chk("unexpected_offer", {27'd0, tp_code}, 32'hFFFF_FFFF);
            end else begin
                tx_t t;
                t = exp_tx.pop_front();
                chk("offer_code", {27'd0, tp_code}, {27'd0, t.code});
                chk("offer_figs", {31'd0, tp_figs}, {31'd0, t.figs});
            end
        end
        if (ep_done) begin
            if (exp_done.size() == 0) begin
                chk("unexpected_ep_done", cyc, 32'hFFFF_FFFF);
            end else begin
                chk("ep_done_cycle", cyc, exp_done.pop_front());
            end
        end
        prev_stall = tp_valid && !tp_ready;
        prev_code  = tp_code;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_in    = '0;
        tp_ready   = 1'b1;
        step(3);

        // Reset state.
        chk("rst_valid", {31'd0, tp_valid}, 32'd0);
        chk("rst_busy", {31'd0, tp_busy}, 32'd0);
        chk("rst_ep_done", {31'd0, ep_done}, 32'd0);
        chk("rst_err", {31'd0, err_overrun}, 32'd0);
        chk("rst_code", {27'd0, tp_code}, 32'd0);
        chk("rst_figs", {31'd0, tp_figs}, 32'd0);
        rst_n = 1'b1;
        step(2);
        chk("idle_ready_no_effect", {31'd0, tp_busy}, 32'd0);

        // Basic print: offer at +1, PRINT +2..+5, ep_done +6, idle +7.
        push_tx(5'b00101, 1'b0);
        send(5'b00101, c0);
        exp_done.push_back(c0 + 6);
        chk("basic_valid_c1", {31'd0, tp_valid}, 32'd1);
        step(1);
        chk("basic_busy_print", {31'd0, tp_busy}, 32'd1);
        chk("basic_valid_print", {31'd0, tp_valid}, 32'd0);
        step(5);
        chk("basic_busy_after", {31'd0, tp_busy}, 32'd0);
        step(2);

        // Backpressure: ready low for 10 offer cycles delays ep_done by 10.
        tp_ready = 1'b0;
        push_tx(5'b00101, 1'b0);
        send(5'b00101, c0);
        exp_done.push_back(c0 + 16);
        step(10);
        tp_ready = 1'b1;
        step(6);
        chk("bp_busy_after", {31'd0, tp_busy}, 32'd0);
        step(2);

        // Overrun during PRINT: flag sticks, current character finishes as is.
        push_tx(5'b10010, 1'b0);
        send(5'b10010, c0);
        exp_done.push_back(c0 + 6);
        step(2);
        char_valid = 1'b1;
        char_in    = 5'b11111;
        step(1);
        char_valid = 1'b0;
        chk("ovr_err_set", {31'd0, err_overrun}, 32'd1);
        step(2);
        chk("ovr_done_now", {31'd0, ep_done}, 32'd1);
        chk("ovr_code_kept", {27'd0, tp_code}, 32'h12);
        step(3);
        chk("ovr_err_sticky", {31'd0, err_overrun}, 32'd1);
        chk("ovr_no_extra", {31'd0, tp_busy}, 32'd0);

        // Reset in PRINT at timer=2 (second PRINT cycle).
        push_tx(5'b00110, 1'b0);
        send(5'b00110, c0);
        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("midrst_valid", {31'd0, tp_valid}, 32'd0);
        chk("midrst_busy", {31'd0, tp_busy}, 32'd0);
        chk("midrst_ep_done", {31'd0, ep_done}, 32'd0);
        chk("midrst_err", {31'd0, err_overrun}, 32'd0);
        chk("midrst_code", {27'd0, tp_code}, 32'd0);
        step(8);
        push_tx(5'b00111, 1'b0);
        send(5'b00111, c0);
        exp_done.push_back(c0 + 6);
        step(7);

`ifdef TP_SHIFT_TRACK_EN
        // Figure shift is absorbed: PRINT +1..+4, ep_done +5.
        send(5'b01011, c0);
        exp_done.push_back(c0 + 5);
        chk("figs_not_offered", {31'd0, tp_valid}, 32'd0);
        chk("figs_busy", {31'd0, tp_busy}, 32'd1);
        step(5);
        push_tx(5'b00001, 1'b1);
        send(5'b00001, c0);
        exp_done.push_back(c0 + 6);
        step(6);
        send(5'b01111, c0);
        exp_done.push_back(c0 + 5);
        step(5);
        chk("ltrs_figs_clear", {31'd0, tp_figs}, 32'd0);
        push_tx(5'b00001, 1'b0);
        send(5'b00001, c0);
        exp_done.push_back(c0 + 6);
        step(6);
`else
        // No shift tracking: figure-shift code is offered raw with figs=0.
        push_tx(5'b01011, 1'b0);
        send(5'b01011, c0);
        exp_done.push_back(c0 + 6);
        chk("raw_shift_valid", {31'd0, tp_valid}, 32'd1);
        step(6);
`endif

        step(4);
        chk("tx_queue_drained", exp_tx.size(), 32'd0);
        chk("done_queue_drained", exp_done.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
